raizing_palette: RTL and testbench
==================================

Name: raizing_palette

Overview:
Pixel stage directly downstream of the layer colour mixer. It takes the mixer's 11-bit palette index each pixel and looks it up in a 2048 x 16-bit xBGR555 palette RAM. It outputs 8-bit-per-channel RGB, with blanking and sync delayed to stay aligned with the colour. It also owns the CPU port to the palette RAM (request/ack handshake) and a clear sequencer that zeroes the RAM after reset.

Parameters:
PAL_AW, 11, palette address width; depth is 2**PAL_AW entries
CLEAR_ON_RESET, 1, 1 = walk and zero the whole RAM after reset; 0 = skip, DONE immediately

Ports:
CLK96  in  1  single clock for the whole block
RESET96_N  in  1  synchronous, active-low reset
PIXEL_CEN  in  1  pixel clock enable; asserted at most once every 3 CLK96 cycles
PAL_IDX  in  11  palette index from the colour mixer (0 = backdrop entry)
ACTIVE  in  1  display-active flag, timed with PAL_IDX
HSYNC_IN  in  1  horizontal sync, timed with PAL_IDX
VSYNC_IN  in  1  vertical sync, timed with PAL_IDX
CPU_REQ  in  1  CPU access request; level, held until CPU_ACK
CPU_WE  in  1  1 = write, 0 = read
CPU_BE  in  2  byte enables; [1] = D15:8, [0] = D7:0
CPU_ADDR  in  11  palette word address
CPU_DIN  in  16  write data
CPU_DOUT  out  16  read data, valid in the CPU_ACK cycle
CPU_ACK  out  1  one-cycle completion pulse
RED  out  8  red output
GREEN  out  8  green output
BLUE  out  8  blue output
HSYNC  out  1  delayed HSYNC_IN
VSYNC  out  1  delayed VSYNC_IN
BLANK_N  out  1  delayed ACTIVE
CLEAR_DONE  out  1  1 once the clear sequence has finished

Behaviour:
- RAM: true dual port.
  - Port A: pixel read, or clear write while clearing.
  - Port B: CPU access.
  - Reads are registered (1 cycle) and read-first: a same-cycle same-address CPU write returns the old data on port A.
- Reset (RESET96_N = 0 at a clock edge):
  - RED, GREEN, BLUE = 0; HSYNC = VSYNC = 0; BLANK_N = 0; CPU_ACK = 0; CPU_DOUT = 0.
  - CLEAR_DONE = 0, clear address = 0.
  - FSM goes to CLEAR (or IDLE if CLEAR_ON_RESET = 0).
  - Any CPU request in flight is dropped with no ACK.
  - RAM contents are not reset; the clear sequence handles them.
- Clear sequencer:
  - Writes 0 to addresses 0..2047, one per cycle, on port A.
  - After writing address 2047, CLEAR_DONE rises on the next cycle.
  - Reset during the clear restarts from address 0.
  - During the clear: RGB is forced to 0, sync and BLANK_N still pipeline normally, CPU_REQ is not serviced (held off).
- CPU FSM: IDLE -> (CPU_REQ && CLEAR_DONE) -> ACCESS -> ACKW -> IDLE.
  - ACCESS: RAM op issued. A write merges CPU_DIN into the enabled bytes only; CPU_BE = 00 writes nothing but still ACKs.
  - ACKW: CPU_ACK = 1 for one cycle; a read latches CPU_DOUT here.
  - CPU_REQ must drop in the ACK cycle; if it is still high in IDLE, that is a new request.
  - Back-to-back accesses: an ACK every 3 cycles.
- Pixel pipeline:
  - On PIXEL_CEN edge N: latch PAL_IDX as the port A address; latch ACTIVE, HSYNC_IN and VSYNC_IN into stage 1.
  - RAM data is ready at N+1.
  - On the next PIXEL_CEN edge: register RED/GREEN/BLUE, BLANK_N, HSYNC and VSYNC from stage 1.
  - Latency: exactly one PIXEL_CEN period for all outputs; outputs hold between enables.
- Colour format, word D:
  - R5 = D[4:0], G5 = D[9:5], B5 = D[14:10]; D[15] is ignored.
  - Each channel expands as {c5, c5[4:2]}, so 0 -> 0x00 and 31 -> 0xFF.
  - A stage-1 ACTIVE of 0 forces RGB to 0.

Decomposition:
- Shared package:
  - PAL_AW and palette depth.
  - xBGR555 field positions.
  - 5->8 expansion function.
  - CPU FSM state encoding: IDLE, CLEAR, ACCESS, ACKW.
- Sub-module: raizing_palette_ram, a generic true-dual-port read-first RAM with per-byte write enable on port B. The top level holds the FSM, the clear sequencer and the pixel pipeline.

Test Plan:
- Reset, with CLEAR_ON_RESET = 1, hold RESET96_N = 1 -> CLEAR_DONE rises 2049 cycles after reset release; a read of address 0x7FF returns 0x0000.
- CPU write 0x7FFF to addr 5 with BE = 11, then read addr 5 -> ACK 3 cycles after REQ each time; CPU_DOUT = 0x7FFF.
- Pixel: entry 5 = 0x001F, PAL_IDX = 5 with ACTIVE = 1 on a CEN; CEN period 4 -> at the next CEN: RED = 0xFF, GREEN = 0x00, BLUE = 0x00, BLANK_N = 1.
- Byte enable: entry 9 = 0x1234; write 0xABCD with BE = 01 -> read returns 0x12CD.
- ACTIVE = 0 with PAL_IDX = 5 -> RGB = 0, BLANK_N = 0; HSYNC/VSYNC pulses appear exactly one CEN period later.
- CPU_REQ asserted mid-clear, then reset asserted at clear address 1000 -> no ACK; clear restarts from address 0; ACK arrives only after CLEAR_DONE.

Source files
------------

// File: rtl/raizing_palette_pkg.sv
// raizing_palette_pkg: shared constants, xBGR555 field layout, 5->8 colour expansion, CPU FSM states
package raizing_palette_pkg;
  localparam int PAL_AW_DEF = 11;
  localparam int PAL_DEPTH_DEF = 2 ** PAL_AW_DEF;
  localparam int R_LSB = 0;
  localparam int G_LSB = 5;
  localparam int B_LSB = 10;
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_ACCESS, ST_ACKW} cpu_state_t;
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction
endpackage

// File: rtl/raizing_palette_ram.sv
// raizing_palette_ram: true dual-port read-first RAM, registered reads, per-byte write enable on port B
//   i_clk                   clock
//   i_a_addr/i_a_we/i_a_din port A address, full-word write enable, write data
//   o_a_dout                port A registered read data (old data on same-cycle write)
//   i_b_addr/i_b_we/i_b_be  port B address, write enable, byte enables
//   i_b_din/o_b_dout        port B write data, registered read data
module raizing_palette_ram #(
  parameter int AW = 11,
  parameter int DW = 16
) (
  input  logic            i_clk,
  input  logic [AW-1:0]   i_a_addr,
  input  logic            i_a_we,
  input  logic [DW-1:0]   i_a_din,
  output logic [DW-1:0]   o_a_dout,
  input  logic [AW-1:0]   i_b_addr,
  input  logic            i_b_we,
  input  logic [DW/8-1:0] i_b_be,
  input  logic [DW-1:0]   i_b_din,
  output logic [DW-1:0]   o_b_dout
);
  localparam int NB = DW / 8;
  logic [DW-1:0] r_mem [2 ** AW];
  always_ff @(posedge i_clk) begin
    o_a_dout <= r_mem[i_a_addr];
    o_b_dout <= r_mem[i_b_addr];
    if (i_a_we) r_mem[i_a_addr] <= i_a_din;
    for (int i = 0; i < NB; i++)
      if (i_b_we && i_b_be[i]) r_mem[i_b_addr][i*8 +: 8] <= i_b_din[i*8 +: 8];
  end
endmodule

// File: rtl/raizing_palette.sv
// raizing_palette: palette lookup stage with CPU access port and post-reset RAM clear
//   CLK96, RESET96_N          clock, synchronous active-low reset
//   PIXEL_CEN                 pixel enable
//   PAL_IDX, ACTIVE, HSYNC_IN, VSYNC_IN   pixel inputs from the colour mixer
//   CPU_REQ/WE/BE/ADDR/DIN    CPU request (level, held until CPU_ACK)
//   CPU_DOUT, CPU_ACK         CPU read data and one-cycle completion pulse
//   RED, GREEN, BLUE          8-bit colour, one pixel enable behind PAL_IDX
//   HSYNC, VSYNC, BLANK_N     syncs and blanking aligned with the colour
//   CLEAR_DONE                high once the palette has been zeroed
module raizing_palette
  import raizing_palette_pkg::*;
#(
  parameter int PAL_AW = PAL_AW_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK96,
  input  logic              RESET96_N,
  input  logic              PIXEL_CEN,
  input  logic [PAL_AW-1:0] PAL_IDX,
  input  logic              ACTIVE,
  input  logic              HSYNC_IN,
  input  logic              VSYNC_IN,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [1:0]        CPU_BE,
  input  logic [PAL_AW-1:0] CPU_ADDR,
  input  logic [15:0]       CPU_DIN,
  output logic [15:0]       CPU_DOUT,
  output logic              CPU_ACK,
  output logic [7:0]        RED,
  output logic [7:0]        GREEN,
  output logic [7:0]        BLUE,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic              BLANK_N,
  output logic              CLEAR_DONE
);
  cpu_state_t        r_state;
  logic [PAL_AW:0]   r_clr_addr;
  logic              r_clear_done;
  logic              r_cpu_ack;
  logic [15:0]       r_cpu_dout;
  logic [PAL_AW-1:0] r_pix_addr;
  logic              r_s1_active, r_s1_hs, r_s1_vs;
  logic [7:0]        r_red, r_green, r_blue;
  logic              r_hsync, r_vsync, r_blank_n;
  logic              w_clearing, w_show, w_unused;
  logic [PAL_AW-1:0] w_a_addr;
  logic [15:0]       w_a_dout, w_b_dout;
  assign w_clearing = r_state == ST_CLEAR;
  assign w_a_addr   = w_clearing ? r_clr_addr[PAL_AW-1:0] : r_pix_addr;
  assign w_show     = r_s1_active && !w_clearing;
  assign w_unused   = w_a_dout[15];
  // The clear address carries one extra bit: once it reaches the depth the walk
  // has finished writing the last entry, and CLEAR_DONE follows one cycle later.
  raizing_palette_ram #(.AW(PAL_AW), .DW(16)) u_ram (
    .i_clk    (CLK96),
    .i_a_addr (w_a_addr),
    .i_a_we   (w_clearing && !r_clr_addr[PAL_AW]),
    .i_a_din  (16'h0000),
    .o_a_dout (w_a_dout),
    .i_b_addr (CPU_ADDR),
    .i_b_we   (r_state == ST_ACCESS && CPU_WE),
    .i_b_be   (CPU_BE),
    .i_b_din  (CPU_DIN),
    .o_b_dout (w_b_dout)
  );
  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      r_state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      r_clr_addr   <= '0;
      r_clear_done <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_cpu_dout   <= 16'h0000;
    end else begin
      r_cpu_ack <= 1'b0;
      case (r_state)
        ST_CLEAR:
          if (r_clr_addr[PAL_AW]) begin
            r_state      <= ST_IDLE;
            r_clear_done <= 1'b1;
          end else r_clr_addr <= r_clr_addr + (PAL_AW+1)'(1);
        ST_IDLE: begin
          r_clear_done <= 1'b1;
          if (CPU_REQ && r_clear_done) r_state <= ST_ACCESS;
        end
        ST_ACCESS: r_state <= ST_ACKW;
        ST_ACKW: begin
          r_state   <= ST_IDLE;
          r_cpu_ack <= 1'b1;
          if (!CPU_WE) r_cpu_dout <= w_b_dout;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      r_pix_addr  <= '0;
      r_s1_active <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_red       <= 8'h00;
      r_green     <= 8'h00;
      r_blue      <= 8'h00;
      r_hsync     <= 1'b0;
      r_vsync     <= 1'b0;
      r_blank_n   <= 1'b0;
    end else if (PIXEL_CEN) begin
      r_pix_addr  <= PAL_IDX;
      r_s1_active <= ACTIVE;
      r_s1_hs     <= HSYNC_IN;
      r_s1_vs     <= VSYNC_IN;
      r_red       <= w_show ? expand5(w_a_dout[R_LSB +: 5]) : 8'h00;
      r_green     <= w_show ? expand5(w_a_dout[G_LSB +: 5]) : 8'h00;
      r_blue      <= w_show ? expand5(w_a_dout[B_LSB +: 5]) : 8'h00;
      r_hsync     <= r_s1_hs;
      r_vsync     <= r_s1_vs;
      r_blank_n   <= r_s1_active;
    end
  end
  assign CPU_DOUT   = r_cpu_dout;
  assign CPU_ACK    = r_cpu_ack;
  assign RED        = r_red;
  assign GREEN      = r_green;
  assign BLUE       = r_blue;
  assign HSYNC      = r_hsync;
  assign VSYNC      = r_vsync;
  assign BLANK_N    = r_blank_n;
  assign CLEAR_DONE = r_clear_done;
endmodule

// File: tb/tb_raizing_palette.sv
// tb_raizing_palette: scoreboard bench with a behavioural palette model and random CPU/pixel traffic
module tb_raizing_palette;
  import raizing_palette_pkg::*;
  logic        CLK96 = 1'b0, RESET96_N = 1'b0, PIXEL_CEN = 1'b0;
  logic [10:0] PAL_IDX = '0, CPU_ADDR = '0;
  logic        ACTIVE = 1'b0, HSYNC_IN = 1'b0, VSYNC_IN = 1'b0;
  logic        CPU_REQ = 1'b0, CPU_WE = 1'b0;
  logic [1:0]  CPU_BE = 2'b00;
  logic [15:0] CPU_DIN = '0;
  logic [15:0] CPU_DOUT;
  logic        CPU_ACK, HSYNC, VSYNC, BLANK_N, CLEAR_DONE;
  logic [7:0]  RED, GREEN, BLUE;

  always #5 CLK96 = ~CLK96;

  raizing_palette dut (
    .CLK96(CLK96), .RESET96_N(RESET96_N), .PIXEL_CEN(PIXEL_CEN), .PAL_IDX(PAL_IDX),
    .ACTIVE(ACTIVE), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN), .CPU_REQ(CPU_REQ),
    .CPU_WE(CPU_WE), .CPU_BE(CPU_BE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
    .CPU_DOUT(CPU_DOUT), .CPU_ACK(CPU_ACK), .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .BLANK_N(BLANK_N), .CLEAR_DONE(CLEAR_DONE)
  );

  typedef struct packed {logic rd; logic [15:0] d;} cpu_exp_t;
  int          checks = 0, errors = 0;
  cpu_exp_t    cpu_q[$];
  logic [26:0] pix_q[$];
  logic [15:0] model [PAL_DEPTH_DEF];
  logic [10:0] p_idx = '0;
  logic        p_act = 1'b0, p_hs = 1'b0, p_vs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 5-bit channel to 8 bits: top 5 bits are the value, low 3 bits repeat its top 3
  function automatic logic [7:0] e8(input int c);
    return 8'(c * 8 + c / 4);
  endfunction

  function automatic logic [26:0] pix_exp(input logic [10:0] idx, input logic act, input logic hs,
                                          input logic vs, input bit clr);
    int d;
    logic [23:0] rgb;
    d = int'(model[idx]);
    rgb = (act && !clr) ? {e8(d % 32), e8((d / 32) % 32), e8((d / 1024) % 32)} : 24'h0;
    return {rgb, act, hs, vs};
  endfunction

  always @(negedge CLK96) begin : mon_cpu
    cpu_exp_t e;
    if (CPU_ACK) begin
      if (cpu_q.size() == 0) chk("cpu_unexpected_ack", 32'(cpu_q.size()), 1);
      else begin
        e = cpu_q.pop_front();
        if (e.rd) chk("cpu_dout", CPU_DOUT, e.d);
      end
    end
  end

  always @(posedge CLK96) begin : mon_pix
    logic [26:0] e;
    if (PIXEL_CEN && RESET96_N && pix_q.size() > 0) begin
      e = pix_q.pop_front();
      #1 chk("pixel_rgb_blank_hs_vs", {RED, GREEN, BLUE, BLANK_N, HSYNC, VSYNC}, e);
    end
  end

  task automatic do_reset();
    RESET96_N = 1'b0;
    PIXEL_CEN = 1'b0;
    repeat (3) @(negedge CLK96);
    chk("reset_rgb", {RED, GREEN, BLUE}, 0);
    chk("reset_ctl", {HSYNC, VSYNC, BLANK_N, CPU_ACK, CLEAR_DONE}, 0);
    chk("reset_dout", CPU_DOUT, 0);
    p_idx = '0; p_act = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
    foreach (model[i]) model[i] = 16'h0000;
  endtask

  task automatic cen_set(input logic [10:0] idx, input logic act, input logic hs, input logic vs,
                         input bit clr);
    pix_q.push_back(pix_exp(p_idx, p_act, p_hs, p_vs, clr));
    p_idx = idx; p_act = act; p_hs = hs; p_vs = vs;
    PAL_IDX = idx; ACTIVE = act; HSYNC_IN = hs; VSYNC_IN = vs;
    PIXEL_CEN = 1'b1;
  endtask

  task automatic pix_cen(input logic [10:0] idx, input logic act, input logic hs, input logic vs,
                         input int gap);
    @(negedge CLK96);
    cen_set(idx, act, hs, vs, 1'b0);
    @(negedge CLK96);
    PIXEL_CEN = 1'b0;
    repeat (gap - 2) @(negedge CLK96);
  endtask

  task automatic cpu_op(input logic we, input logic [1:0] be, input logic [10:0] a,
                        input logic [15:0] din);
    int n;
    @(negedge CLK96);
    CPU_REQ = 1'b1; CPU_WE = we; CPU_BE = be; CPU_ADDR = a; CPU_DIN = din;
    if (we) begin
      if (be[0]) model[a][7:0] = din[7:0];
      if (be[1]) model[a][15:8] = din[15:8];
      cpu_q.push_back('{1'b0, din});
    end else cpu_q.push_back('{1'b1, model[a]});
    n = 0;
    do begin @(negedge CLK96); n++; end while (!CPU_ACK && n < 20);
    CPU_REQ = 1'b0;
    chk("cpu_ack_latency", n, 3);
  endtask

  task automatic cpu_b2b(input logic [10:0] a);
    int n1, n2;
    @(negedge CLK96);
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_BE = 2'b11; CPU_ADDR = a;
    cpu_q.push_back('{1'b1, model[a]});
    cpu_q.push_back('{1'b1, model[a]});
    n1 = 0;
    do begin @(negedge CLK96); n1++; end while (!CPU_ACK && n1 < 20);
    n2 = 0;
    do begin @(negedge CLK96); n2++; end while (!CPU_ACK && n2 < 20);
    CPU_REQ = 1'b0;
    chk("b2b_first_ack", n1, 3);
    chk("b2b_second_ack", n2, 3);
  endtask

  initial begin
    int n;
    bit saw;
    do_reset();
    RESET96_N = 1'b1;
    n = 0;
    do begin
      @(negedge CLK96);
      n++;
      PIXEL_CEN = 1'b0;
      if (n % 4 == 0 && n < 2000)
        cen_set(11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end while (!CLEAR_DONE && n < 3000);
    PIXEL_CEN = 1'b0;
    chk("clear_done_latency", n, 2049);
    cpu_op(1'b0, 2'b11, 11'h7FF, 16'h0);
    cpu_op(1'b1, 2'b11, 11'd5, 16'h7FFF);
    cpu_op(1'b0, 2'b11, 11'd5, 16'h0);
    cpu_op(1'b1, 2'b11, 11'd9, 16'h1234);
    cpu_op(1'b1, 2'b01, 11'd9, 16'hABCD);
    cpu_op(1'b0, 2'b11, 11'd9, 16'h0);
    cpu_op(1'b1, 2'b11, 11'd5, 16'h001F);
    pix_cen(11'd5, 1'b1, 1'b0, 1'b0, 4);
    pix_cen(11'd5, 1'b0, 1'b1, 1'b0, 4);
    pix_cen(11'd5, 1'b0, 1'b0, 1'b1, 4);
    pix_cen(11'd0, 1'b0, 1'b0, 1'b0, 4);
    cpu_b2b(11'd9);
    for (int i = 0; i < 40; i++)
      cpu_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 11'($urandom_range(0, 15)),
             16'($urandom));
    for (int i = 0; i < 60; i++)
      pix_cen(($urandom_range(0, 7) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 15)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(3, 6));
    // request raised mid-clear, then reset lands at clear address 1000
    do_reset();
    RESET96_N = 1'b1;
    n = 0;
    saw = 1'b0;
    do begin
      @(negedge CLK96);
      n++;
      if (CPU_ACK) saw = 1'b1;
      if (n == 100) begin
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_BE = 2'b11; CPU_ADDR = 11'd5;
        cpu_q.push_back('{1'b1, 16'h0000});
      end
    end while (n < 1000);
    do_reset();
    chk("midclear_no_ack", saw, 0);
    RESET96_N = 1'b1;
    n = 0;
    do begin @(negedge CLK96); n++; end while (!CPU_ACK && n < 2200);
    CPU_REQ = 1'b0;
    chk("midclear_ack_latency", n, 2052);
    chk("midclear_done_at_ack", CLEAR_DONE, 1);
    cpu_op(1'b1, 2'b00, 11'd7, 16'hFFFF);
    cpu_op(1'b0, 2'b11, 11'd7, 16'h0);
    cpu_op(1'b0, 2'b11, 11'd9, 16'h0);
    repeat (5) @(negedge CLK96);
    chk("cpu_queue_drained", 32'(cpu_q.size()), 0);
    chk("pix_queue_drained", 32'(pix_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
